// File: rtl/avg_drain.sv
// Captures the moving-average sum once per 64-cycle frame, divides by four and queues the result.
// Optional AVG_ROUND_EN macro selects round-half-up instead of truncation.
module avg_drain #(
  parameter int CAPTURE_PHASE = 4,
  parameter int WARMUP_FRAMES = 4,
  parameter int DEPTH         = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] sum_in,
  output logic [63:0] avg_out,
  output logic        avg_valid,
  input  logic        avg_ready,
  output logic [4:0]  fill,
  output logic        overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [5:0]             frame_q, frame_d;
  logic [2:0]             warm_q, warm_d;
  logic [AW-1:0]          wptr_q, wptr_d;
  logic [AW-1:0]          rptr_q, rptr_d;
  logic [4:0]             fill_q, fill_d;
  logic                   ovf_q, ovf_d;
  logic [DEPTH-1:0][63:0] mem_q;

  logic        capture, warm_done, push_req, full, empty, pop, push, drop;
  logic [63:0] push_val;

`ifdef AVG_ROUND_EN
  // 66-bit sum so the +2 carry out of an all-ones word is not lost
  assign push_val = 64'(({2'b00, sum_in} + 66'd2) >> 2);
`else
  assign push_val = sum_in >> 2;
`endif

  assign capture   = (frame_q == 6'(CAPTURE_PHASE));
  assign warm_done = (warm_q >= 3'(WARMUP_FRAMES));
  assign push_req  = capture && warm_done;
  assign full      = (fill_q == 5'(DEPTH));
  assign empty     = (fill_q == 5'd0);
  assign pop       = !empty && avg_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  always_comb begin
    frame_d = frame_q + 6'd1;
    warm_d  = warm_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    fill_d  = fill_q;
    ovf_d   = ovf_q || drop;
    if (capture && !warm_done) warm_d = warm_q + 3'd1;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   fill_d = fill_q + 5'd1;
      2'b01:   fill_d = fill_q - 5'd1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '0;
      warm_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fill_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      frame_q <= frame_d;
      warm_q  <= warm_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fill_q  <= fill_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once fill is cleared
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wptr_q] <= push_val;
  end

  assign avg_valid = !empty;
  assign avg_out   = empty ? 64'h0 : mem_q[rptr_q];
  assign fill      = fill_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_avg_drain.sv
// Directed bench for avg_drain: stimulus queues expected words, a negedge monitor checks every pop.
module tb_avg_drain;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] sum_in = 64'h0;
  logic        avg_ready = 1'b0;
  logic [63:0] avg_out;
  logic        avg_valid;
  logic [4:0]  fill;
  logic        overflow;

  avg_drain dut (
    .clk      (clk),
    .reset    (reset),
    .sum_in   (sum_in),
    .avg_out  (avg_out),
    .avg_valid(avg_valid),
    .avg_ready(avg_ready),
    .fill     (fill),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // cyc = index of the next rising edge (cycle 0 = first edge after reset drops)
  int cyc = 0;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];

`ifdef AVG_ROUND_EN
  localparam logic [63:0] EXP_7  = 64'h2;
  localparam logic [63:0] EXP_FF = 64'h4000_0000_0000_0000;
  localparam logic [63:0] EXP_3  = 64'h1;
`else
  localparam logic [63:0] EXP_7  = 64'h1;
  localparam logic [63:0] EXP_FF = 64'h3FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] EXP_3  = 64'h0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int n);
    int k = 0;
    while (cyc != n && k < 5000) begin
      step();
      k++;
    end
    if (cyc != n) begin
      checks++;
      errors++;
      $display("FAIL go_to_timeout: got cyc %0d expected %0d", cyc, n);
    end
  endtask

  // Reset edge with a capture/pop attempt allowed to coincide, then reset-state checks
  task automatic do_reset(input logic rdy_during);
    reset     = 1'b1;
    avg_ready = rdy_during;
    exp_q.delete();
    step();
    step();
    reset     = 1'b0;
    avg_ready = 1'b0;
    check("rst_valid", 64'(avg_valid), 64'h0);
    check("rst_fill", 64'(fill), 64'h0);
    check("rst_overflow", 64'(overflow), 64'h0);
    check("rst_avg_out", avg_out, 64'h0);
  endtask

  // Discard four warm-up captures, then push 0x10,0x20,0x30,0x40 with the consumer stalled
  task automatic fill4();
    do_reset(1'b0);
    for (int k = 0; k <= 7; k++) begin
      go_to(64 * k + 2);
      sum_in = (k < 4) ? 64'hDEAD_BEEF_0000_0003 : 64'(64 * (k - 3));
      if (k >= 4) exp_q.push_back(64'(16 * (k - 3)));
    end
    go_to(453);
    check("fill4_fill", 64'(fill), 64'h4);
    check("fill4_overflow", 64'(overflow), 64'h0);
    check("fill4_head", avg_out, 64'h10);
    go_to(514);
    sum_in = 64'h140;
  endtask

  always @(negedge clk) begin
    if (!reset && avg_valid && avg_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got %h expected no word", avg_out);
      end else begin
        check("pop_data", avg_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Constant input, warm-up timing, truncation/rounding corners
    do_reset(1'b0);
    avg_ready = 1'b1;
    sum_in    = 64'h10;
    exp_q.push_back(64'h4);
    go_to(260);
    check("warmup_valid_low", 64'(avg_valid), 64'h0);
    check("warmup_fill", 64'(fill), 64'h0);
    go_to(261);
    check("first_valid", 64'(avg_valid), 64'h1);
    check("first_word", avg_out, 64'h4);
    check("first_fill", 64'(fill), 64'h1);
    go_to(262);
    check("empty_valid", 64'(avg_valid), 64'h0);
    check("empty_out_zero", avg_out, 64'h0);
    sum_in = 64'h7;
    exp_q.push_back(EXP_7);
    go_to(325);
    check("second_valid", 64'(avg_valid), 64'h1);
    go_to(330);
    sum_in = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_q.push_back(EXP_FF);
    go_to(400);
    sum_in = 64'h3;
    exp_q.push_back(EXP_3);
    go_to(460);
    check("a_drained", 64'(exp_q.size()), 64'h0);
    check("a_fill", 64'(fill), 64'h0);

    // Full FIFO drops the fifth capture and latches overflow
    fill4();
    go_to(516);
    check("pre_drop_overflow", 64'(overflow), 64'h0);
    go_to(517);
    check("drop_overflow", 64'(overflow), 64'h1);
    check("drop_fill", 64'(fill), 64'h4);
    check("drop_head", avg_out, 64'h10);
    go_to(520);
    avg_ready = 1'b1;
    go_to(530);
    check("b_drained", 64'(exp_q.size()), 64'h0);
    check("b_fill", 64'(fill), 64'h0);
    check("b_overflow_sticky", 64'(overflow), 64'h1);

    // Simultaneous push and pop while full
    fill4();
    go_to(516);
    avg_ready = 1'b1;
    exp_q.push_back(64'h50);
    go_to(517);
    avg_ready = 1'b0;
    check("pp_full_fill", 64'(fill), 64'h4);
    check("pp_full_overflow", 64'(overflow), 64'h0);
    check("pp_full_head", avg_out, 64'h20);
    go_to(520);
    avg_ready = 1'b1;
    go_to(530);
    check("c_drained", 64'(exp_q.size()), 64'h0);
    check("c_fill", 64'(fill), 64'h0);

    // Push/pop with one entry, then reset coinciding with a capture and a pop
    do_reset(1'b0);
    go_to(200);
    sum_in = 64'h20;
    exp_q.push_back(64'h8);
    go_to(262);
    check("d_one_fill", 64'(fill), 64'h1);
    sum_in = 64'h30;
    exp_q.push_back(64'hC);
    go_to(324);
    avg_ready = 1'b1;
    go_to(325);
    avg_ready = 1'b0;
    check("pp_one_fill", 64'(fill), 64'h1);
    check("pp_one_valid", 64'(avg_valid), 64'h1);
    check("pp_one_head", avg_out, 64'hC);
    go_to(388);
    do_reset(1'b1);
    sum_in = 64'h10;
    exp_q.push_back(64'h4);
    go_to(260);
    check("rewarm_valid_low", 64'(avg_valid), 64'h0);
    go_to(261);
    check("rewarm_valid", 64'(avg_valid), 64'h1);
    check("rewarm_fill", 64'(fill), 64'h1);
    avg_ready = 1'b1;
    go_to(265);
    check("d_drained", 64'(exp_q.size()), 64'h0);
    check("d_fill", 64'(fill), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avg_drain.md
AVG_DRAIN -- requirements
Module: avg_drain

Interface
REQ-001 Parameter CAPTURE_PHASE, default 4: frame-counter value at which sum_in is sampled (0..63).
REQ-002 Parameter WARMUP_FRAMES, default 4: number of initial captures discarded after reset (0..7).
REQ-003 Parameter DEPTH, default 4: output FIFO entries (power of two, 2..16).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sum_in  input  64  unsigned 4-tap sum word from the upstream moving-average datapath.
REQ-007 avg_out  output  64  head-of-FIFO average word.
REQ-008 avg_valid  output  1  high when the FIFO holds at least one entry.
REQ-009 avg_ready  input  1  consumer accepts the head entry on a rising edge where avg_valid=1.
REQ-010 fill  output  5  current FIFO occupancy (0..DEPTH).
REQ-011 overflow  output  1  sticky flag: a capture was dropped because the FIFO was full.

Function
REQ-012 The block SHALL run a 6-bit frame counter: 0 at reset, +1 every cycle, 63 wraps to 0.
REQ-013 Capture strobe SHALL be high in the cycle where counter == CAPTURE_PHASE; sum_in is sampled on that rising edge.
REQ-014 A 3-bit warm-up counter SHALL discard the first WARMUP_FRAMES captures (no push, no overflow); it then saturates and every later capture is a push request.
REQ-015 Pushed value SHALL be sum_in >> 2 (logical, unsigned, truncating) unless AVG_ROUND_EN applies.
REQ-016 A pushed word SHALL appear (avg_valid=1, fill updated) in the cycle after the capture edge; latency 1 cycle.
REQ-017 A pop SHALL occur on any edge where avg_valid=1 and avg_ready=1; avg_ready while empty has no effect.
REQ-018 avg_out SHALL equal the head entry while avg_valid=1 and 64'h0 while empty.
REQ-019 FIFO order SHALL be first-in first-out; pointers wrap modulo DEPTH.
REQ-020 Push while full with no simultaneous pop: word dropped, contents unchanged, overflow set next cycle.
REQ-021 Push and pop on the same edge while full: both SHALL be accepted; fill unchanged; overflow not set.
REQ-022 Push and pop on the same edge while holding exactly 1 entry: new word becomes head; fill stays 1; avg_valid stays high.
REQ-023 overflow SHALL stay high until reset.

Reset
REQ-024 On a rising edge with reset=1: frame counter, warm-up counter, FIFO pointers and fill SHALL be cleared to 0; overflow=0; avg_valid=0; avg_out=0.
REQ-025 Reset mid-operation SHALL discard all buffered words and restart warm-up; no partial state survives.
REQ-026 A capture or pop coinciding with reset SHALL be ignored; reset has priority.

Configuration
REQ-027 Macro AVG_ROUND_EN defined: pushed value SHALL be (sum_in + 2) >> 2, evaluated at 66 bits, low 64 bits kept (round-half-up).
REQ-028 Macro AVG_ROUND_EN undefined: pushed value SHALL be sum_in >> 2; no rounding adder is instantiated.

Verification
(Cycle 0 = first edge after reset deasserts; default parameters.)
REQ-029 sum_in=64'h10 constant, avg_ready=1 -> captures at 4,68,132,196 discarded; avg_valid first high at cycle 261 with avg_out=64'h4; then one word per 64 cycles.
REQ-030 sum_in=64'h7 -> avg_out=64'h1 without AVG_ROUND_EN, 64'h2 with; sum_in=64'hFFFF_FFFF_FFFF_FFFF -> 64'h3FFF_FFFF_FFFF_FFFF without, 64'h4000_0000_0000_0000 with.
REQ-031 avg_ready=0, sum_in incrementing each frame -> pushes at 260,324,388,452, fill=4; capture at 516 dropped; overflow=1 from cycle 517; draining returns the four words in push order.
REQ-032 Same as REQ-031 but avg_ready=1 for the single edge at 516 -> oldest word popped, new word pushed, fill=4, overflow stays 0.
REQ-033 Reset pulsed for one edge at cycle 300 with 1 entry buffered -> avg_valid=0, fill=0, overflow=0 next cycle; next avg_valid rises 261 cycles after the reset edge.
